div_repsub: RTL

Unsigned integer divider that computes quotient and remainder by repeated subtraction. It is the inverse companion of the team's repeated-addition multiplier, built the same way: a start/done-handshaked FSM driving a small subtract/count datapath. It sits beside the multiplier in the arithmetic unit and needs no clock-enable or pipeline interface. Latency depends on the data: quotient + 2 cycles.

---
 rtl/div_repsub_if.sv | 23 ++
 rtl/div_repsub.sv | 89 ++++++++
 2 files changed

// File: rtl/div_repsub_if.sv
// Start/done handshake and operand/result bundle for the repeated-subtraction divider.
interface div_repsub_if #(
    parameter int unsigned W = 16
) ();
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction: one subtract per cycle, quotient + 2 cycle latency.
module div_repsub #(
    parameter int unsigned W = 16
) (
    input logic         clk,
    input logic         rst,
    div_repsub_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StSub,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] r_q, r_d;
    logic [W-1:0] d_q, d_d;
    logic [W-1:0] q_q, q_d;
    logic         done_q, done_d;
    logic         dbz_q, dbz_d;
    logic         r_ge_d;

    assign r_ge_d = (r_q >= d_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            d_q     <= d_d;
            q_q     <= q_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        d_d     = d_q;
        q_d     = q_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    r_d = bus.dividend;
                    if (bus.divisor == '0) begin
                        // Divide by zero finishes at once with an all-ones quotient.
                        q_d     = '1;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        d_d     = bus.divisor;
                        q_d     = '0;
                        done_d  = 1'b0;
                        dbz_d   = 1'b0;
                        state_d = StSub;
                    end
                end
            end
            StSub: begin
                if (r_ge_d) begin
                    r_d = r_q - d_q;
                    q_d = q_q + 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.quotient    = q_q;
    assign bus.remainder   = r_q;
    assign bus.busy        = (state_q == StSub);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule
